// File: rtl/loanio_uart_pkg.sv
// Shared types and helpers for loanio_uart: parity modes, TX/RX FSM states, divisor and parity functions.
package loanio_uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } par_mode_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP
  } rx_state_e;

  function automatic int uart_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  // Parity bit to transmit for zero-extended data; odd mode makes data+parity carry an odd count of ones.
  function automatic logic uart_par(input logic [8:0] data, input par_mode_e mode);
    case (mode)
      PAR_ODD:  return ~(^data);
      PAR_EVEN: return ^data;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/loanio_uart_rx_fifo.sv
// First-word-fall-through RX FIFO, zero read latency; a push while full is refused unless a pop frees space
// in the same cycle. DEPTH must be a power of two >= 2.
module loanio_uart_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk_clk,
  input  logic         reset_reset_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         wr_en, rd_en;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en   = pop_rdy & ~empty;
  assign wr_en   = push_vld & (~full | rd_en);
  assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/loanio_uart.sv
// Fabric UART on HPS loan-I/O pins: TX line registered (low 1 clk after the edge after handshake), rx_valid 1 clk
// after stop sample; tx_ready only when idle, RX full drops+flags overrun. LOANIO_UART_RX_FIFO_EN selects FIFO vs holding reg.
module loanio_uart
  import loanio_uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int LOAN_W     = 67,
  parameter int TX_PIN     = 49,
  parameter int RX_PIN     = 50,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  input  logic                 rx_err_clr,
  input  logic [LOAN_W-1:0]    loan_io_in,
  output logic [LOAN_W-1:0]    loan_io_out,
  output logic [LOAN_W-1:0]    loan_io_oe
);

  localparam int              DIV      = uart_div(CLK_HZ, BAUD);
  localparam int              CW       = $clog2(STOP_BITS * DIV + 1);
  localparam logic [CW-1:0]   BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0]   HALF_END = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0]   STOP_END = CW'(STOP_BITS * DIV - 1);
  localparam logic [3:0]      LAST_BIT = 4'(DATA_BITS - 1);
  localparam par_mode_e       PMODE    = par_mode_e'(PARITY);

  tx_state_e              tx_state_q, tx_state_d;
  logic [CW-1:0]          tx_cnt_q, tx_cnt_d;
  logic [3:0]             tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]   tx_shr_q, tx_shr_d;
  logic                   tx_par_q, tx_par_d;
  logic                   tx_line_q, tx_line_d;

  rx_state_e              rx_state_q, rx_state_d;
  logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
  logic [3:0]             rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]   rx_shr_q, rx_shr_d;
  logic                   rx_pbit_q, rx_pbit_d;
  logic                   rx_meta_q, rx_sync_q, rx_prev_q;
  logic                   rx_push, rx_pop, rx_drop;
  logic [DATA_BITS-1:0]   buf_dat;
  logic                   ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d;
  logic                   unused_loan_in;

  assign unused_loan_in = ^loan_io_in;
  assign tx_ready       = (tx_state_q == TX_IDLE);

  always_comb begin
    loan_io_out         = '0;
    loan_io_out[TX_PIN] = tx_line_q;
    loan_io_oe          = '0;
    loan_io_oe[TX_PIN]  = 1'b1;
  end

  // Line value follows the current state, so it lags the state register by exactly one clock.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shr_d   = tx_shr_q;
    tx_par_d   = tx_par_q;
    tx_line_d  = 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_valid) begin
          tx_shr_d   = tx_data;
          tx_par_d   = uart_par(9'(tx_data), PMODE);
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        tx_line_d = 1'b0;
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_line_d = tx_shr_q[0];
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          tx_shr_d = tx_shr_q >> 1;
          tx_bit_d = tx_bit_q + 4'd1;
          if (tx_bit_q == LAST_BIT) tx_state_d = (PMODE == PAR_NONE) ? TX_STOP : TX_PAR;
        end
      end
      TX_PAR: begin
        tx_line_d = tx_par_q;
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == STOP_END) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shr_d   = rx_shr_q;
    rx_pbit_d  = rx_pbit_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          rx_shr_d = {rx_sync_q, rx_shr_q[DATA_BITS-1:1]};
          rx_bit_d = rx_bit_q + 4'd1;
          if (rx_bit_q == LAST_BIT) rx_state_d = (PMODE == PAR_NONE) ? RX_STOP : RX_PAR;
        end
      end
      RX_PAR: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_pbit_d  = rx_sync_q;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_push    = 1'b1;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign rx_pop  = rx_valid & rx_ready;
  assign rx_data = rx_valid ? buf_dat : '0;

`ifdef LOANIO_UART_RX_FIFO_EN
  logic fifo_full, fifo_empty;

  loanio_uart_rx_fifo #(
    .W     (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .push_vld      (rx_push),
    .push_dat      (rx_shr_q),
    .pop_rdy       (rx_ready),
    .pop_dat       (buf_dat),
    .full          (fifo_full),
    .empty         (fifo_empty)
  );

  assign rx_valid = ~fifo_empty;
  assign rx_drop  = rx_push & fifo_full & ~rx_pop;
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;
  logic                 hold_vld_q, hold_vld_d;
  logic [DATA_BITS-1:0] hold_dat_q, hold_dat_d;

  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_dat_d = hold_dat_q;
    if (rx_pop) hold_vld_d = 1'b0;
    if (rx_push && (!hold_vld_q || rx_pop)) begin
      hold_vld_d = 1'b1;
      hold_dat_d = rx_shr_q;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hold_vld_q <= 1'b0;
      hold_dat_q <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_dat_q <= hold_dat_d;
    end
  end

  assign rx_valid = hold_vld_q;
  assign buf_dat  = hold_dat_q;
  assign rx_drop  = rx_push & hold_vld_q & ~rx_pop;
`endif

  // A clear in the same cycle as an error wins, so software never loses a clear to a racing set.
  always_comb begin
    ferr_d = rx_err_clr ? 1'b0 : (ferr_q | (rx_push & ~rx_sync_q));
    perr_d = rx_err_clr ? 1'b0 :
             (perr_q | (rx_push & (PMODE != PAR_NONE) & (rx_pbit_q != uart_par(9'(rx_shr_q), PMODE))));
    ovr_d  = rx_err_clr ? 1'b0 : (ovr_q | rx_drop);
  end

  assign rx_frame_err  = ferr_q;
  assign rx_parity_err = perr_q;
  assign rx_overrun    = ovr_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shr_q   <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shr_q   <= '0;
      rx_pbit_q  <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shr_q   <= tx_shr_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shr_q   <= rx_shr_d;
      rx_pbit_q  <= rx_pbit_d;
      rx_meta_q  <= loan_io_in[RX_PIN];
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      ovr_q      <= ovr_d;
    end
  end

endmodule
